sdp_ram_arbiter: RTL and testbench
==================================

// Module: sdp_ram_arbiter
// PURPOSE
//  Shares one simple-dual-port block RAM (1 write port A, 1 read port B with 1-cycle registered read) between two
//  masters. Each master issues reads/writes over valid/ready; writes are arbitrated onto port A, reads onto port B,
//  independently, each with its own round-robin. Per-master read responses use valid/ready with a 1-entry skid buffer.
// PARAMETERS
//  DATA_WIDTH  32    RAM word width
//  DATA_DEPTH  1024  RAM words; ADDR_WIDTH = ceil(log2(DATA_DEPTH)), derived, not overridable
// PORTS
//  clk            in   1     clock; single clock domain
//  rst_n          in   1     asynchronous, active-low reset
//  mX_req_valid   in   1     (X=0,1) request valid
//  mX_req_ready   out  1     request accepted this cycle (combinational from valid/state)
//  mX_req_we      in   1     1=write, 0=read
//  mX_req_addr    in   ADDR_WIDTH  word address
//  mX_req_wdata   in   DATA_WIDTH  write data
//  mX_rsp_valid   out  1     read data valid
//  mX_rsp_ready   in   1     master accepts read data
//  mX_rsp_rdata   out  DATA_WIDTH  read data
//  ram_ena/ram_wea  out 1    port A enable/write-enable (both = write grant)
//  ram_addra      out  ADDR_WIDTH  port A address;  ram_dia  out DATA_WIDTH  port A data
//  ram_enb        out  1     port B read enable (= read grant)
//  ram_addrb      out  ADDR_WIDTH  port B address;  ram_dob  in  DATA_WIDTH  port B data, valid 1 cycle after enb
//  RAM's own sync reset is tied low by the parent.
// BEHAVIOUR
//  Reset: rd_ptr=wr_ptr=0 (master 0 favoured), pend=0, pend_id=0, buf_valid[1:0]=0, buf_data=0. Reset may assert
//   at any time; in-flight reads and buffered data are discarded, every rsp_valid drops to 0 immediately.
//  Write path: cand_w[i] = mi_req_valid & mi_req_we. Round-robin picks one; favoured = wr_ptr, else the other.
//   Granted master gets req_ready=1 that cycle; ram_ena=ram_wea=1, addra/dia muxed from it. wr_ptr <= ~granted.
//   No grant -> ram_ena=ram_wea=0, addra/dia=0.
//  Read path: cand_r[i] = mi_req_valid & ~mi_req_we & ~buf_valid[i] & ~(pend & pend_id==i & ~mi_rsp_ready).
//   Round-robin with rd_ptr as above; grant -> ram_enb=1, addrb muxed, req_ready=1, pend<=1, pend_id<=i,
//   rd_ptr<=~i. No grant -> ram_enb=0 (dob holds), pend<=0.
//  Response for master i: rsp_valid = buf_valid[i] | (pend & pend_id==i); rsp_rdata = buf_valid[i] ? buf_data[i]
//   : ram_dob. If pend & pend_id==i & ~rsp_ready -> buf_valid[i]<=1, buf_data[i]<=ram_dob.
//   buf_valid[i] & rsp_ready -> buf_valid[i]<=0. pend data and buf for one master never coexist (cand_r rule).
//  Latency: read handshake at cycle t -> rsp_valid at t+1; throughput 1 read + 1 write per cycle in total;
//   a single master with rsp_ready held high sustains 1 read/cycle.
//  Ordering: per master, responses return in request order. Read/write same address, same cycle: read returns old data.
//  A master may present valid=1 with we toggling only after handshake; req_valid must not depend on req_ready.
//  Both masters valid for same port: alternate every cycle while both stay valid (no starvation).
// STRUCTURE
//  Shared package/include: log2 function for ADDR_WIDTH, master ID constants M0=0, M1=1.
//  Sub-module rr_arb2: 2-way round-robin arbiter (req[1:0], advance, grant[1:0], ptr flop), instantiated for
//   the read and write paths. Data/address muxes and response buffers in the top.
// TESTING
//  Reset then m0 write addr 5 data 0xDEADBEEF, m0 read 5 -> m0_rsp_valid next cycle, rdata 0xDEADBEEF.
//  m0,m1 both read continuously, rsp_ready=1 -> grants alternate m0,m1,m0,... ram_enb=1 every cycle.
//  m1 read addr 7 with m1_rsp_ready=0 for 3 cycles -> data held in buf, further m1 reads not granted, m0 still served.
//  Same cycle write addr 3 = 0x11 (m0) and read addr 3 (m1), old value 0x22 -> m1 gets 0x22; later read gets 0x11.
//  Both masters write each cycle -> one write/cycle, alternating; no lost writes, final RAM content matches model.
//  rst_n pulsed low while pend=1 and buf_valid[0]=1 -> all rsp_valid=0, ram_ena/enb=0, ptrs back to master 0.

Source files
------------

// File: rtl/sdp_ram_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sdp_ram_arbiter_pkg
//   Shared definitions for the simple-dual-port RAM arbiter slice:
//   master identifiers and the address-width helper used to size the
//   RAM address from its depth.
// -----------------------------------------------------------------------------
package sdp_ram_arbiter_pkg;

  // Master identifiers; also the encoding of the pending-read owner.
  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_id_e;

  // Ceiling log2, clamped to at least 1 bit so a one-word RAM still has
  // a legal address port.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/sdp_ram_arbiter_if.sv
// -----------------------------------------------------------------------------
// sdp_ram_arbiter_if
//   One master's request/response channel to the RAM arbiter.
//   Request : req_valid/req_ready handshake carrying we, addr, wdata.
//   Response: rsp_valid/rsp_ready handshake carrying rdata (reads only).
//   Modports:
//     master - the requester (drives request fields and rsp_ready)
//     slave  - the arbiter   (drives req_ready and the response)
// -----------------------------------------------------------------------------
interface sdp_ram_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/sdp_ram_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
//   Two-way round-robin arbiter. The pointer names the favoured requester;
//   when it is not requesting, the other requester wins. After a consumed
//   grant the pointer moves to the master that did not win, so two
//   persistent requesters alternate every cycle.
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset (pointer -> M0)
//     req[1:0]    request per master
//     advance     grant is consumed this cycle (update the pointer)
//     grant[1:0]  one-hot grant, combinational from req and pointer
// -----------------------------------------------------------------------------
module rr_arb2
  import sdp_ram_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr;

  // NOTE: every combinational output gets a default before any branch so no
  // path leaves it unassigned; otherwise a latch is inferred.
  always_comb begin
    grant = '0;
    if (req[ptr]) begin
      grant[ptr] = 1'b1;
    end else if (req[~ptr]) begin
      grant[~ptr] = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= M0;
    end else if (advance && (grant != 2'b00)) begin
      // Favour the loser next time: winner M1 -> ptr M0, winner M0 -> ptr M1.
      ptr <= ~grant[1];
    end
  end

endmodule

// File: rtl/sdp_ram_arbiter.sv
// -----------------------------------------------------------------------------
// sdp_ram_arbiter
//   Shares one simple-dual-port block RAM (write port A, registered read
//   port B) between two masters. Writes and reads are arbitrated
//   independently, each with its own round-robin, so one write and one read
//   can be issued per cycle. Each master's read response has a one-entry
//   skid buffer that captures RAM data when the master stalls.
//   Ports:
//     clk, rst_n              clock, asynchronous active-low reset
//     m0, m1                  master channels (sdp_ram_arbiter_if.slave)
//     ram_ena, ram_wea        port A enable / write enable (= write grant)
//     ram_addra, ram_dia      port A address / write data (0 when idle)
//     ram_enb                 port B read enable (= read grant)
//     ram_addrb               port B address (0 when idle)
//     ram_dob                 port B read data, valid one cycle after enb
// -----------------------------------------------------------------------------
module sdp_ram_arbiter
  import sdp_ram_arbiter_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int DATA_DEPTH = 1024,
  localparam int ADDR_WIDTH = clog2(DATA_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sdp_ram_arbiter_if.slave      m0,
  sdp_ram_arbiter_if.slave      m1,
  output logic                  ram_ena,
  output logic                  ram_wea,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [DATA_WIDTH-1:0] ram_dia,
  output logic                  ram_enb,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  input  logic [DATA_WIDTH-1:0] ram_dob
);

  // Master signals gathered into vectors indexed by master id.
  logic [1:0]            req_valid;
  logic [1:0]            req_we;
  logic [1:0]            rsp_ready;
  logic [ADDR_WIDTH-1:0] req_addr  [2];
  logic [DATA_WIDTH-1:0] req_wdata [2];

  assign req_valid    = {m1.req_valid, m0.req_valid};
  assign req_we       = {m1.req_we,    m0.req_we};
  assign rsp_ready    = {m1.rsp_ready, m0.rsp_ready};
  assign req_addr[0]  = m0.req_addr;
  assign req_addr[1]  = m1.req_addr;
  assign req_wdata[0] = m0.req_wdata;
  assign req_wdata[1] = m1.req_wdata;

  // Read-response state: one read in flight (pend/pend_id) plus a skid
  // buffer per master.
  logic                  pend;
  master_id_e            pend_id;
  logic [1:0]            buf_valid;
  logic [DATA_WIDTH-1:0] buf_data [2];
  logic [1:0]            pend_for;

  assign pend_for = {pend && (pend_id == M1), pend && (pend_id == M0)};

  logic [1:0] cand_w, cand_r, gnt_w, gnt_r;

  // A master may only launch a read when neither its buffer nor an
  // unaccepted in-flight read is occupying its single response slot.
  assign cand_w = req_valid & req_we;
  assign cand_r = req_valid & ~req_we & ~buf_valid & ~(pend_for & ~rsp_ready);

  // Grants are always taken in the same cycle (ready is combinational), so
  // both pointers advance on every grant.
  rr_arb2 u_wr_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (cand_w),
    .advance (1'b1),
    .grant   (gnt_w)
  );

  rr_arb2 u_rd_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (cand_r),
    .advance (1'b1),
    .grant   (gnt_r)
  );

  // Port A / port B muxes; idle ports drive zero address and data.
  always_comb begin
    ram_ena   = |gnt_w;
    ram_wea   = |gnt_w;
    ram_addra = '0;
    ram_dia   = '0;
    if (gnt_w[1]) begin
      ram_addra = req_addr[1];
      ram_dia   = req_wdata[1];
    end else if (gnt_w[0]) begin
      ram_addra = req_addr[0];
      ram_dia   = req_wdata[0];
    end

    ram_enb   = |gnt_r;
    ram_addrb = '0;
    if (gnt_r[1]) begin
      ram_addrb = req_addr[1];
    end else if (gnt_r[0]) begin
      ram_addrb = req_addr[0];
    end
  end

  assign m0.req_ready = gnt_w[0] | gnt_r[0];
  assign m1.req_ready = gnt_w[1] | gnt_r[1];

  // Response: buffered data has priority; otherwise the live RAM output for
  // the read issued last cycle.
  assign m0.rsp_valid = buf_valid[0] | pend_for[0];
  assign m1.rsp_valid = buf_valid[1] | pend_for[1];
  assign m0.rsp_rdata = buf_valid[0] ? buf_data[0] : ram_dob;
  assign m1.rsp_rdata = buf_valid[1] ? buf_data[1] : ram_dob;

  // NOTE: the skid-buffer data registers are reset as well as their valid
  // flags so the read-data outputs are deterministic after reset; the RAM
  // array itself is external and deliberately not cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend        <= 1'b0;
      pend_id     <= M0;
      buf_valid   <= '0;
      buf_data[0] <= '0;
      buf_data[1] <= '0;
    end else begin
      pend <= |gnt_r;
      if (|gnt_r) begin
        pend_id <= gnt_r[1] ? M1 : M0;
      end
      for (int i = 0; i < 2; i++) begin
        if (pend_for[i] && !rsp_ready[i]) begin
          // Master stalled: park the RAM output before port B moves on.
          buf_valid[i] <= 1'b1;
          buf_data[i]  <= ram_dob;
        end else if (buf_valid[i] && rsp_ready[i]) begin
          buf_valid[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sdp_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdp_ram_arbiter
//   Directed and randomized stimulus for sdp_ram_arbiter against a word-array
//   reference memory. Accepted reads push the model's current word into a
//   per-master queue; a monitor pops and compares whenever a response is
//   taken, and checks rsp_valid against queue occupancy every cycle.
// -----------------------------------------------------------------------------
module tb_sdp_ram_arbiter;
  import sdp_ram_arbiter_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 1024;
  localparam int AW    = clog2(DEPTH);

  logic clk = 1'b0;
  logic rst_n;
  logic ram_clear;
  always #5 clk = ~clk;

  sdp_ram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) m0 ();
  sdp_ram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) m1 ();

  logic          ram_ena, ram_wea, ram_enb;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [DW-1:0] ram_dia, ram_dob;

  sdp_ram_arbiter #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m0        (m0),
    .m1        (m1),
    .ram_ena   (ram_ena),
    .ram_wea   (ram_wea),
    .ram_addra (ram_addra),
    .ram_dia   (ram_dia),
    .ram_enb   (ram_enb),
    .ram_addrb (ram_addrb),
    .ram_dob   (ram_dob)
  );

  // Simple-dual-port block RAM: read-first, dob holds when enb is low.
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (ram_clear) begin
      for (int j = 0; j < DEPTH; j++) ram[j] <= '0;
      ram_dob <= '0;
    end else begin
      if (ram_enb) ram_dob <= ram[ram_addrb];
      if (ram_ena && ram_wea) ram[ram_addra] <= ram_dia;
    end
  end

  // ---------------------------------------------------------------- checking
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [1:0]    req_v_s, req_r_s, req_we_s, rsp_v_s, rsp_r_s;
  logic [AW-1:0] addr_s [2];
  logic [DW-1:0] wd_s [2];
  logic [DW-1:0] rd_s [2];

  assign req_v_s  = {m1.req_valid, m0.req_valid};
  assign req_r_s  = {m1.req_ready, m0.req_ready};
  assign req_we_s = {m1.req_we,    m0.req_we};
  assign rsp_v_s  = {m1.rsp_valid, m0.rsp_valid};
  assign rsp_r_s  = {m1.rsp_ready, m0.rsp_ready};
  assign addr_s[0] = m0.req_addr;
  assign addr_s[1] = m1.req_addr;
  assign wd_s[0]   = m0.req_wdata;
  assign wd_s[1]   = m1.req_wdata;
  assign rd_s[0]   = m0.rsp_rdata;
  assign rd_s[1]   = m1.rsp_rdata;

  // Reference memory and per-master expected-response queues.
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] q0 [$];
  logic [DW-1:0] q1 [$];
  logic [1:0]    acc;

  always @(negedge clk) begin
    int            sz;
    logic [DW-1:0] e;
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      acc = '0;
      if (ram_clear) for (int j = 0; j < DEPTH; j++) model[j] = '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        sz = (i == 0) ? q0.size() : q1.size();
        check($sformatf("m%0d_rsp_valid", i), {31'b0, rsp_v_s[i]}, {31'b0, sz != 0});
        if (rsp_v_s[i] && rsp_r_s[i] && sz != 0) begin
          e = (i == 0) ? q0.pop_front() : q1.pop_front();
          check($sformatf("m%0d_rsp_rdata", i), rd_s[i], e);
        end
      end
      acc = req_v_s & req_r_s;
      if (req_v_s == 2'b11 && req_we_s == 2'b11)
        check("one_write_grant", {30'b0, acc}, {30'b0, acc[0] ? 2'b01 : 2'b10});
      // Reads see memory before this cycle's write.
      for (int i = 0; i < 2; i++) begin
        if (acc[i] && !req_we_s[i]) begin
          if (i == 0) q0.push_back(model[addr_s[i]]);
          else        q1.push_back(model[addr_s[i]]);
        end
      end
      for (int i = 0; i < 2; i++)
        if (acc[i] && req_we_s[i]) model[addr_s[i]] = wd_s[i];
    end
  end

  // ---------------------------------------------------------------- stimulus
  typedef struct packed {
    logic          v;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } req_t;

  req_t cur [2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input logic we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    cur[i] = '{v: v, we: we, a: a, d: d};
    if (i == 0) begin
      m0.req_valid = v; m0.req_we = we; m0.req_addr = a; m0.req_wdata = d;
    end else begin
      m1.req_valid = v; m1.req_we = we; m1.req_addr = a; m1.req_wdata = d;
    end
  endtask

  task automatic set_rdy(input logic r0, input logic r1);
    m0.rsp_ready = r0;
    m1.rsp_ready = r1;
  endtask

  // Present a new request only once the previous one was accepted (or none
  // was valid); mode 0 random, 1 write-only, 2 read-only.
  task automatic next_req(input int i, input int mode);
    req_t r;
    if (!cur[i].v || acc[i]) begin
      r.d = $urandom;
      case (mode)
        1:       begin r.v = 1'b1; r.we = 1'b1; r.a = AW'(16 + $urandom_range(0, 15)); end
        2:       begin r.v = 1'b1; r.we = 1'b0; r.a = AW'($urandom_range(0, 31)); end
        default: begin
          r.v  = ($urandom_range(0, 3) != 0);
          r.we = 1'($urandom_range(0, 1));
          r.a  = AW'($urandom_range(0, 15));
        end
      endcase
      drive(i, r.v, r.we, r.a, r.d);
    end
  endtask

  task automatic idle();
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    logic prev;
    bit   done;
    int   mism;

    ram_clear = 1'b1;
    rst_n     = 1'b0;
    idle();
    set_rdy(1'b1, 1'b1);
    repeat (2) @(posedge clk);

    // Reset state.
    @(negedge clk);
    check("rst_m0_rsp_valid", {31'b0, m0.rsp_valid}, 0);
    check("rst_m1_rsp_valid", {31'b0, m1.rsp_valid}, 0);
    check("rst_ram_ena",      {31'b0, ram_ena}, 0);
    check("rst_ram_enb",      {31'b0, ram_enb}, 0);
    check("rst_ram_addra",    DW'(ram_addra), 0);
    tick();
    ram_clear = 1'b0;
    rst_n     = 1'b1;

    // Write then read back one word.
    drive(0, 1'b1, 1'b1, AW'(5), 32'hDEADBEEF);
    @(negedge clk);
    check("wr_m0_ready", {31'b0, m0.req_ready}, 1);
    check("wr_ram_ena",  {31'b0, ram_ena}, 1);
    check("wr_ram_wea",  {31'b0, ram_wea}, 1);
    check("wr_ram_addra", DW'(ram_addra), 5);
    check("wr_ram_dia",  ram_dia, 32'hDEADBEEF);
    tick();
    drive(0, 1'b1, 1'b0, AW'(5), '0);
    @(negedge clk);
    check("rd_m0_ready", {31'b0, m0.req_ready}, 1);
    check("rd_ram_enb",  {31'b0, ram_enb}, 1);
    check("rd_ram_addrb", DW'(ram_addrb), 5);
    check("rd_ram_ena_idle", {31'b0, ram_ena}, 0);
    tick();
    idle();
    @(negedge clk);
    check("rd_m0_rsp_valid", {31'b0, m0.rsp_valid}, 1);
    check("rd_m0_rsp_rdata", m0.rsp_rdata, 32'hDEADBEEF);

    // Both masters read continuously: grants alternate, m1 first since m0
    // won the previous read.
    prev = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      next_req(0, 2);
      next_req(1, 2);
      @(negedge clk);
      check("alt_rd_enb", {31'b0, ram_enb}, 1);
      check("alt_rd_onehot", {31'b0, m0.req_ready ^ m1.req_ready}, 1);
      if (k == 0) check("alt_rd_first_m1", {31'b0, m1.req_ready}, 1);
      else        check("alt_rd_toggle", {31'b0, m0.req_ready}, {31'b0, ~prev});
      prev = m0.req_ready;
    end
    tick();
    idle();

    // m1 stalls its response: buffer holds data, m1 blocked, m0 served.
    tick();
    set_rdy(1'b1, 1'b0);
    drive(1, 1'b1, 1'b0, AW'(7), '0);
    @(negedge clk);
    check("stall_m1_first_ready", {31'b0, m1.req_ready}, 1);
    for (int j = 0; j < 3; j++) begin
      tick();
      drive(1, 1'b1, 1'b0, AW'(8), '0);
      drive(0, 1'b1, 1'b0, AW'(9 + j), '0);
      @(negedge clk);
      check("stall_m1_blocked", {31'b0, m1.req_ready}, 0);
      check("stall_m0_served",  {31'b0, m0.req_ready}, 1);
      check("stall_m1_rsp_held", {31'b0, m1.rsp_valid}, 1);
    end
    tick();
    set_rdy(1'b1, 1'b1);
    drive(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("drain_m1_still_blocked", {31'b0, m1.req_ready}, 0);
    done = 1'b0;
    for (int j = 0; j < 4 && !done; j++) begin
      tick();
      @(negedge clk);
      if (m1.req_valid && m1.req_ready) done = 1'b1;
    end
    check("drain_m1_granted", {31'b0, done}, 1);
    tick();
    idle();

    // Same-cycle write and read of one address: read returns old data.
    tick();
    drive(0, 1'b1, 1'b1, AW'(3), 32'h22);
    @(negedge clk);
    tick();
    drive(0, 1'b1, 1'b1, AW'(3), 32'h11);
    drive(1, 1'b1, 1'b0, AW'(3), '0);
    @(negedge clk);
    check("rw_ram_ena", {31'b0, ram_ena}, 1);
    check("rw_ram_enb", {31'b0, ram_enb}, 1);
    check("rw_both_ready", {30'b0, m1.req_ready, m0.req_ready}, 3);
    tick();
    idle();
    @(negedge clk);
    check("rw_old_data", m1.rsp_rdata, 32'h22);
    tick();
    drive(1, 1'b1, 1'b0, AW'(3), '0);
    @(negedge clk);
    tick();
    idle();
    @(negedge clk);
    check("rw_new_data", m1.rsp_rdata, 32'h11);

    // Both masters write every cycle: one write per cycle, alternating.
    prev = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tick();
      next_req(0, 1);
      next_req(1, 1);
      @(negedge clk);
      check("alt_wr_ena", {31'b0, ram_ena}, 1);
      check("alt_wr_onehot", {31'b0, m0.req_ready ^ m1.req_ready}, 1);
      if (k > 0) check("alt_wr_toggle", {31'b0, m0.req_ready}, {31'b0, ~prev});
      prev = m0.req_ready;
    end
    tick();
    idle();
    for (int a = 16; a < 32; a++) begin
      tick();
      drive(0, 1'b1, 1'b0, AW'(a), '0);
      @(negedge clk);
    end
    tick();
    idle();

    // Randomized traffic with random response back-pressure.
    for (int k = 0; k < 1500; k++) begin
      tick();
      set_rdy(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
      next_req(0, 0);
      next_req(1, 0);
      @(negedge clk);
    end
    tick();
    idle();
    set_rdy(1'b1, 1'b1);
    for (int j = 0; j < 20 && (q0.size() != 0 || q1.size() != 0); j++) begin
      @(negedge clk);
      tick();
    end
    @(negedge clk);
    check("drain_queues_empty", DW'(q0.size() + q1.size()), 0);

    // Reset while m0 holds buffered data and m1 has a read in flight.
    tick();
    set_rdy(1'b0, 1'b1);
    drive(0, 1'b1, 1'b0, AW'(4), '0);
    @(negedge clk);
    check("rst_seq_m0_ready", {31'b0, m0.req_ready}, 1);
    tick();
    drive(0, 1'b0, 1'b0, '0, '0);
    set_rdy(1'b0, 1'b0);
    drive(1, 1'b1, 1'b0, AW'(6), '0);
    @(negedge clk);
    tick();
    drive(1, 1'b0, 1'b0, '0, '0);
    check("pre_rst_m0_buffered", {31'b0, m0.rsp_valid}, 1);
    check("pre_rst_m1_pending",  {31'b0, m1.rsp_valid}, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_m0_rsp_valid", {31'b0, m0.rsp_valid}, 0);
    check("async_rst_m1_rsp_valid", {31'b0, m1.rsp_valid}, 0);
    check("async_rst_ram_ena", {31'b0, ram_ena}, 0);
    check("async_rst_ram_enb", {31'b0, ram_enb}, 0);
    tick();
    rst_n = 1'b1;
    set_rdy(1'b1, 1'b1);
    drive(0, 1'b1, 1'b1, AW'(40), 32'hA5A5_0040);
    drive(1, 1'b1, 1'b1, AW'(41), 32'h5A5A_0041);
    @(negedge clk);
    check("post_rst_wr_m0_first", {30'b0, m1.req_ready, m0.req_ready}, 1);
    tick();
    drive(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("post_rst_wr_m1_next", {31'b0, m1.req_ready}, 1);
    tick();
    drive(0, 1'b1, 1'b0, AW'(40), '0);
    drive(1, 1'b1, 1'b0, AW'(41), '0);
    @(negedge clk);
    check("post_rst_rd_m0_first", {30'b0, m1.req_ready, m0.req_ready}, 1);
    tick();
    drive(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("post_rst_rd_m1_next", {31'b0, m1.req_ready}, 1);
    tick();
    idle();
    repeat (3) @(negedge clk);

    // Final RAM contents against the reference memory.
    mism = 0;
    for (int j = 0; j < DEPTH; j++) if (ram[j] !== model[j]) mism++;
    check("final_ram_contents", DW'(mism), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
